// File: rtl/tone_synth_i2s.sv
// tone_synth_i2s: NUM_VOICES square-wave tone voices, saturating mixer and
// left-justified MSB-first DAC serialiser with locally derived AUD_BCLK and
// AUD_DACLRCK. Everything runs on CLOCK_27 with a synchronous active-high Reset.
// Optional build macro TONE_SYNTH_PAN_EN adds a per-voice voice_pan input and
// independent left/right mixes; without it one mix feeds both slots.
module tone_synth_i2s #(
    parameter int NUM_VOICES = 4,
    parameter int DATA_WIDTH = 16,
    parameter int PERIOD_W   = 12,
    parameter int AMP_W      = 14,
    parameter int BCLK_DIV   = 9
) (
    input  logic                           CLOCK_27,
    input  logic                           Reset,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic [NUM_VOICES*PERIOD_W-1:0] voice_period,
    input  logic [NUM_VOICES*AMP_W-1:0]    voice_amp,
`ifdef TONE_SYNTH_PAN_EN
    input  logic [NUM_VOICES*2-1:0]        voice_pan,
`endif
    input  logic                           mute,
    input  logic                           clip_clr,
    output logic                           AUD_BCLK,
    output logic                           AUD_DACLRCK,
    output logic                           AUD_DACDAT,
    output logic                           sample_strobe,
    output logic                           clip
);

    // Mix headroom: 3 guard bits cover up to 8 voices of |amp| < 2^(DATA_WIDTH-1).
    localparam int MIX_W = DATA_WIDTH + 3;
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(2 * DATA_WIDTH);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(BCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_MAX  = BIT_W'(2 * DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(DATA_WIDTH);

    localparam logic signed [MIX_W-1:0] SAT_MAX =
        {{(MIX_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [MIX_W-1:0] SAT_MIN =
        {{(MIX_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // Clamp a wide mix to the DAC range; returns {saturated_flag, sample}.
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [MIX_W-1:0] m);
        logic [DATA_WIDTH:0] r;
        if (m > SAT_MAX) begin
            r = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (m < SAT_MIN) begin
            r = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            r = {1'b0, m[DATA_WIDTH-1:0]};
        end
        return r;
    endfunction

    // Clock generation and frame position
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                    bclk_q, lrck_q, dacdat_q, strobe_q, clip_q;
    logic [2*DATA_WIDTH-1:0] sr_q;
    logic                    sat_cur_q;
    logic                    div_wrap_s, fall_tick_s, frame_start_s;

    // Shadow copies of the voice controls, refreshed only at frame start
    logic [NUM_VOICES-1:0]          en_sh_q;
    logic [NUM_VOICES*PERIOD_W-1:0] per_sh_q;
    logic [NUM_VOICES*AMP_W-1:0]    amp_sh_q;
`ifdef TONE_SYNTH_PAN_EN
    logic [NUM_VOICES*2-1:0]        pan_sh_q;
`endif

    // Voice phase state
    logic [NUM_VOICES-1:0][PERIOD_W-1:0] cnt_q, cnt_d;
    logic [NUM_VOICES-1:0]               sign_q, sign_d;

    // Mixer
    logic signed [MIX_W-1:0] contrib_s, mix_l_s, mix_r_s;
    logic [DATA_WIDTH:0]     sat_l_s, sat_r_s;
    logic [DATA_WIDTH-1:0]   sample_l_s, sample_r_s;
    logic                    frame_sat_s;

    // Divider/bit-counter next state and the tick decodes derived from them.
    always_comb begin
        div_wrap_s    = (div_cnt_q == DIV_MAX);
        fall_tick_s   = div_wrap_s && bclk_q;
        frame_start_s = fall_tick_s && (bit_cnt_q == BIT_MAX);
        div_cnt_d     = div_wrap_s ? '0 : div_cnt_q + DIV_W'(1);
        if (fall_tick_s) begin
            bit_cnt_d = frame_start_s ? '0 : bit_cnt_q + BIT_W'(1);
        end else begin
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Per-voice phase advance using the shadow controls of the previous frame.
    always_comb begin
        cnt_d  = cnt_q;
        sign_d = sign_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!en_sh_q[i] || (per_sh_q[i*PERIOD_W +: PERIOD_W] == '0)) begin
                cnt_d[i]  = '0;
                sign_d[i] = 1'b0;
            end else if (cnt_q[i] >= per_sh_q[i*PERIOD_W +: PERIOD_W] - PERIOD_W'(1)) begin
                // >= rather than == so a shortened period toggles immediately
                cnt_d[i]  = '0;
                sign_d[i] = ~sign_q[i];
            end else begin
                cnt_d[i]  = cnt_q[i] + PERIOD_W'(1);
            end
        end
    end

    // Signed voice contributions summed into left/right mixes, then clamped.
    always_comb begin
        mix_l_s   = '0;
        mix_r_s   = '0;
        contrib_s = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (en_sh_q[i] && (per_sh_q[i*PERIOD_W +: PERIOD_W] != '0)) begin
                contrib_s = $signed({{(MIX_W-AMP_W){1'b0}}, amp_sh_q[i*AMP_W +: AMP_W]});
                contrib_s = sign_q[i] ? -contrib_s : contrib_s;
            end else begin
                contrib_s = '0;
            end
`ifdef TONE_SYNTH_PAN_EN
            mix_l_s = mix_l_s + (pan_sh_q[2*i]   ? contrib_s : '0);
            mix_r_s = mix_r_s + (pan_sh_q[2*i+1] ? contrib_s : '0);
`else
            mix_l_s = mix_l_s + contrib_s;
`endif
        end
`ifndef TONE_SYNTH_PAN_EN
        mix_r_s = mix_l_s;
`endif
        sat_l_s     = saturate(mix_l_s);
        sat_r_s     = saturate(mix_r_s);
        sample_l_s  = mute ? '0 : sat_l_s[DATA_WIDTH-1:0];
        sample_r_s  = mute ? '0 : sat_r_s[DATA_WIDTH-1:0];
        frame_sat_s = ~mute & (sat_l_s[DATA_WIDTH] | sat_r_s[DATA_WIDTH]);
    end

    // Bit clock, frame clock, strobe and serial data path.
    always_ff @(posedge CLOCK_27) begin
        if (Reset) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            bclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
            dacdat_q  <= 1'b0;
            strobe_q  <= 1'b0;
            sr_q      <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            strobe_q  <= frame_start_s;
            if (div_wrap_s) begin
                bclk_q <= ~bclk_q;
            end
            if (fall_tick_s) begin
                lrck_q <= (bit_cnt_d >= BIT_HALF);
                if (frame_start_s) begin
                    dacdat_q <= sample_l_s[DATA_WIDTH-1];
                    sr_q     <= {sample_l_s[DATA_WIDTH-2:0], sample_r_s, 1'b0};
                end else begin
                    dacdat_q <= sr_q[2*DATA_WIDTH-1];
                    sr_q     <= {sr_q[2*DATA_WIDTH-2:0], 1'b0};
                end
            end
        end
    end

    // Frame-start bookkeeping: voice phases, shadow controls, saturation status.
    always_ff @(posedge CLOCK_27) begin
        if (Reset) begin
            cnt_q     <= '0;
            sign_q    <= '0;
            en_sh_q   <= '0;
            per_sh_q  <= '0;
            amp_sh_q  <= '0;
`ifdef TONE_SYNTH_PAN_EN
            pan_sh_q  <= '0;
`endif
            sat_cur_q <= 1'b0;
        end else if (frame_start_s) begin
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            en_sh_q   <= voice_en;
            per_sh_q  <= voice_period;
            amp_sh_q  <= voice_amp;
`ifdef TONE_SYNTH_PAN_EN
            pan_sh_q  <= voice_pan;
`endif
            sat_cur_q <= frame_sat_s;
        end
    end

    // Sticky clip flag; an active saturated frame overrides a clear request.
    always_ff @(posedge CLOCK_27) begin
        if (Reset) begin
            clip_q <= 1'b0;
        end else if (sat_cur_q) begin
            clip_q <= 1'b1;
        end else if (clip_clr) begin
            clip_q <= 1'b0;
        end
    end

    assign AUD_BCLK      = bclk_q;
    assign AUD_DACLRCK   = lrck_q;
    assign AUD_DACDAT    = dacdat_q;
    assign sample_strobe = strobe_q;
    assign clip          = clip_q;

endmodule

// File: tb/tb_tone_synth_i2s.sv
// Scoreboard bench for tone_synth_i2s: the driver pushes the hand-computed
// {left,right} word for each frame at its start; a monitor deserialises the
// DAC stream on AUD_BCLK rising edges and compares whole frames.
module tb_tone_synth_i2s;

    localparam int NV = 4;
    localparam int PW = 12;
    localparam int AW = 14;

    logic          CLOCK_27 = 1'b0;
    logic          Reset    = 1'b1;
    logic [NV-1:0] voice_en = '0;
    logic [NV*PW-1:0] voice_period = '0;
    logic [NV*AW-1:0] voice_amp = '0;
`ifdef TONE_SYNTH_PAN_EN
    logic [NV*2-1:0]  voice_pan = '1;
`endif
    logic mute = 1'b0;
    logic clip_clr = 1'b0;
    logic AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_strobe, clip;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    tone_synth_i2s #(.NUM_VOICES(NV), .DATA_WIDTH(16), .PERIOD_W(PW), .AMP_W(AW), .BCLK_DIV(9)) dut (
        .CLOCK_27(CLOCK_27), .Reset(Reset), .voice_en(voice_en),
        .voice_period(voice_period), .voice_amp(voice_amp),
`ifdef TONE_SYNTH_PAN_EN
        .voice_pan(voice_pan),
`endif
        .mute(mute), .clip_clr(clip_clr), .AUD_BCLK(AUD_BCLK),
        .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT),
        .sample_strobe(sample_strobe), .clip(clip)
    );

    initial forever #5 CLOCK_27 = ~CLOCK_27;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    task automatic set_voice(input int i, input logic en, input logic [PW-1:0] per, input logic [AW-1:0] amp);
        voice_en[i]            = en;
        voice_period[i*PW +: PW] = per;
        voice_amp[i*AW +: AW]    = amp;
    endtask

    // Wait for the next frame start and register the word it will carry.
    task automatic frame(input logic [15:0] l, input logic [15:0] r);
        int t;
        t = 0;
        do begin
            @(negedge CLOCK_27);
            t++;
        end while (!sample_strobe && t < 1200);
        if (!sample_strobe) begin
            n_cmp++;
            n_err++;
            $display("FAIL strobe_timeout: got no strobe within %0d cycles, expected one", t);
            finish_run();
        end
        exp_q.push_back({l, r});
    endtask

    // Monitor: collect 32 bits per frame on BCLK rising edges and score them.
    initial begin
        logic [31:0] rx, lrw, ex;
        int idx;
        logic bclk_prev;
        idx = 0; bclk_prev = 1'b0; rx = '0; lrw = '0;
        forever begin
            @(negedge CLOCK_27);
            if (Reset) begin
                idx = 0;
                bclk_prev = 1'b0;
            end else begin
                if (sample_strobe) check("frame_align", idx, 0);
                if (AUD_BCLK && !bclk_prev) begin
                    rx  = {rx[30:0], AUD_DACDAT};
                    lrw = {lrw[30:0], AUD_DACLRCK};
                    idx++;
                    if (idx == 32) begin
                        idx = 0;
                        if (exp_q.size() == 0) begin
                            check("unexpected_frame", rx, 32'hxxxx_xxxx);
                        end else begin
                            ex = exp_q.pop_front();
                            check("frame_data", rx, ex);
                            check("lrck_pattern", lrw, 32'h0000_FFFF);
                        end
                    end
                end
                bclk_prev = AUD_BCLK;
            end
        end
    end

    // Driver: directed vectors with the expected frame words written out by hand.
    initial begin
        int cyc, r1, r2, lr, t;
        logic prev_b, got;

        set_voice(0, 1'b1, 12'd3, 14'd1000);
        repeat (5) @(posedge CLOCK_27);
        @(negedge CLOCK_27);
        check("reset_outputs", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_strobe, clip}, 5'b0);
        exp_q.push_back(32'h0);          // frame before the first strobe
        Reset = 1'b0;

        cyc = 0; r1 = -1; r2 = -1; lr = -1; prev_b = 1'b0; got = 1'b0;
        while (!got && cyc < 2000) begin
            @(posedge CLOCK_27);
            cyc++;
            @(negedge CLOCK_27);
            if (AUD_BCLK && !prev_b) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            if (AUD_DACLRCK && lr < 0) lr = cyc;
            prev_b = AUD_BCLK;
            if (sample_strobe) got = 1'b1;
        end
        check("first_bclk_rise", r1, 9);
        check("bclk_period", r2 - r1, 18);
        check("lrck_first_rise", lr, 288);
        check("first_strobe", cyc, 576);
        exp_q.push_back(32'h0);          // frame 1 uses reset shadows

        // Single voice, period 3, amp 1000: +1000 x3, -1000 x3 from frame 2
        for (int k = 2; k <= 10; k++) begin
            if (((k - 2) / 3) % 2 == 1) frame(16'hFC18, 16'hFC18);
            else                        frame(16'h03E8, 16'h03E8);
        end
        voice_en = '0;
        frame(16'hFC18, 16'hFC18);       // 11
        for (int i = 0; i < NV; i++) set_voice(i, 1'b1, 12'd3, 14'd16383);
        frame(16'h0000, 16'h0000);       // 12
        check("clip_before_sat", clip, 1'b0);
        frame(16'h7FFF, 16'h7FFF);       // 13
        repeat (5) @(negedge CLOCK_27);
        check("clip_set", clip, 1'b1);
        clip_clr = 1'b1;
        @(negedge CLOCK_27);
        clip_clr = 1'b0;
        check("clip_clr_while_sat", clip, 1'b1);
        voice_en = '0;
        frame(16'h7FFF, 16'h7FFF);       // 14
        frame(16'h0000, 16'h0000);       // 15
        check("clip_sticky", clip, 1'b1);
        clip_clr = 1'b1;
        @(negedge CLOCK_27);
        clip_clr = 1'b0;
        check("clip_cleared", clip, 1'b0);

        // Mute for 10 frames with period 4; phase continues underneath
        set_voice(0, 1'b1, 12'd4, 14'd2000);
        frame(16'h0000, 16'h0000);       // 16
        mute = 1'b1;
        for (int k = 17; k <= 26; k++) frame(16'h0000, 16'h0000);
        mute = 1'b0;
        frame(16'h07D0, 16'h07D0);       // 27
        frame(16'h07D0, 16'h07D0);       // 28
        for (int k = 29; k <= 32; k++) frame(16'hF830, 16'hF830);
        frame(16'h07D0, 16'h07D0);       // 33
        check("clip_after_mute", clip, 1'b0);

        // Period shortened from 100 to 2 mid-frame while cnt = 50
        voice_en = '0;
        frame(16'h07D0, 16'h07D0);       // 34
        set_voice(0, 1'b1, 12'd100, 14'd3000);
        frame(16'h0000, 16'h0000);       // 35
        for (int k = 36; k <= 85; k++) frame(16'h0BB8, 16'h0BB8);
        voice_period[0 +: PW] = 12'd2;
        frame(16'h0BB8, 16'h0BB8);       // 86
        frame(16'h0BB8, 16'h0BB8);       // 87
        frame(16'hF448, 16'hF448);       // 88
        frame(16'hF448, 16'hF448);       // 89
        frame(16'h0BB8, 16'h0BB8);       // 90
        frame(16'h0BB8, 16'h0BB8);       // 91

`ifdef TONE_SYNTH_PAN_EN
        // Voice 0 left only (500), voice 1 right only (700)
        voice_en = '0;
        frame(16'hF448, 16'hF448);       // 92
        set_voice(0, 1'b1, 12'd3, 14'd500);
        set_voice(1, 1'b1, 12'd3, 14'd700);
        voice_pan = 8'b0000_1001;
        frame(16'h0000, 16'h0000);       // 93
        for (int k = 94; k <= 96; k++) frame(16'h01F4, 16'h02BC);
        for (int k = 97; k <= 99; k++) frame(16'hFE0C, 16'hFD44);
`endif

        t = 0;
        while (exp_q.size() != 0 && t < 1200) begin
            @(negedge CLOCK_27);
            t++;
        end
        check("scoreboard_drained", exp_q.size(), 0);

        // Reset mid-frame returns every output to 0 on the next edge
        repeat (100) @(negedge CLOCK_27);
        Reset = 1'b1;
        @(negedge CLOCK_27);
        check("midframe_reset", {AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, sample_strobe, clip}, 5'b0);
        finish_run();
    end

endmodule
